// File: rtl/decoder_pkg.sv
// decoder_pkg
// Shared definitions for the decoder family.
//   state_t            : FSM state encoding (IDLE, DIRECT, SCAN)
//   clog2()            : ceiling log2, used to size counters from parameters
//   onehot_decode_bit(): one bit of a one-hot decode, so any output width can be
//                        built by looping over the output positions
package decoder_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DIRECT = 2'd1,
    SCAN   = 2'd2
  } state_t;

  // Ceiling log2; returns 0 for values of 0 or 1, callers clamp where needed
  function automatic int clog2(input int value);
    int result;
    int remaining;
    result    = 0;
    remaining = value - 1;
    while (remaining > 0) begin
      result    = result + 1;
      remaining = remaining >> 1;
    end
    return result;
  endfunction

  // Bit 'position' of the one-hot decode of 'index'
  function automatic logic onehot_decode_bit(input int unsigned index,
                                             input int unsigned position);
    return (index == position);
  endfunction

endpackage

// File: rtl/div_pulse.sv
// div_pulse
// Prescaler counting 0..DIV_CNT-1 while running; tc is high during the last
// count so the consumer can act on the same edge that wraps the counter.
//   clk : rising-edge clock
//   rst : synchronous active-high reset
//   clr : holds the counter at 0
//   run : advances the counter (ignored while clr is high)
//   tc  : one-cycle terminal-count pulse, combinational from the counter
module div_pulse
  import decoder_pkg::*;
#(
  parameter int DIV_CNT = 50_000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic run,
  output logic tc
);

  // A DIV_CNT of 1 still needs a one-bit counter that simply stays at 0
  localparam int CNT_W = (clog2(DIV_CNT) < 1) ? 1 : clog2(DIV_CNT);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV_CNT - 1);

  logic [CNT_W-1:0] cnt;
  logic             at_last;

  assign at_last = (cnt == LAST);
  assign tc      = run && !clr && at_last;

  // Counter wraps at LAST; clearing takes priority so a fresh run starts at 0
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (run) begin
      if (at_last) begin
        cnt <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/decoder_n_scan.sv
// decoder_n_scan
// SEL_W-to-2^SEL_W one-hot decoder with registered outputs, global enable,
// selectable output polarity and an autonomous scan mode for multiplexed
// displays.
//   sys_clk : rising-edge clock
//   sys_rst : synchronous active-high reset
//   en      : global enable, 0 forces out_0 inactive
//   mode    : 0 = direct index, 1 = scan
//   sel     : direct-mode index
//   sel_vld : load strobe for sel in direct mode
//   out_0   : registered decoded output (one-cold when ACTIVE_LOW)
//   idx     : registered current index
//   step    : one-cycle pulse on each scan advance
module decoder_n_scan
  import decoder_pkg::*;
#(
  parameter  int SEL_W      = 3,
  parameter  int DIV_CNT    = 50_000,
  parameter  bit ACTIVE_LOW = 1'b0,
  localparam int OUT_W      = 2 ** SEL_W
) (
  input  logic             sys_clk,
  input  logic             sys_rst,
  input  logic             en,
  input  logic             mode,
  input  logic [SEL_W-1:0] sel,
  input  logic             sel_vld,
  output logic [OUT_W-1:0] out_0,
  output logic [SEL_W-1:0] idx,
  output logic             step
);

  localparam logic [OUT_W-1:0] POL_MASK = {OUT_W{ACTIVE_LOW}};

  state_t           state_q;
  state_t           state_d;
  logic [SEL_W-1:0] idx_d;
  logic             step_d;
  logic [OUT_W-1:0] dec_d;
  logic             scan_tc;
  logic             scan_clr;
  logic             scan_run;

  // The prescaler only runs while already in SCAN, so it is guaranteed to be
  // at 0 on the cycle SCAN is entered
  assign scan_run = (state_q == SCAN);
  assign scan_clr = (state_q != SCAN);

  div_pulse #(
    .DIV_CNT (DIV_CNT)
  ) u_div_pulse (
    .clk (sys_clk),
    .rst (sys_rst),
    .clr (scan_clr),
    .run (scan_run),
    .tc  (scan_tc)
  );

  // State register
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state follows en/mode directly; index actions are keyed on the state
  // being entered so that a load on a SCAN->DIRECT change wins, and a
  // terminal count on the way out of SCAN does not advance or pulse step
  always_comb begin
    state_d = state_q;
    idx_d   = idx;
    step_d  = 1'b0;
    dec_d   = '0;

    if (!en) begin
      state_d = IDLE;
    end else if (mode) begin
      state_d = SCAN;
    end else begin
      state_d = DIRECT;
    end

    if (state_d == DIRECT && sel_vld) begin
      idx_d = sel;
    end else if (state_d == SCAN && scan_tc) begin
      idx_d  = idx + 1'b1;
      step_d = 1'b1;
    end

    if (state_d != IDLE) begin
      for (int i = 0; i < OUT_W; i++) begin
        dec_d[i] = onehot_decode_bit(32'(idx_d), i);
      end
    end
  end

  // Index, step and output update together so they always agree; polarity is
  // applied as a final XOR
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      idx   <= '0;
      step  <= 1'b0;
      out_0 <= POL_MASK;
    end else begin
      idx   <= idx_d;
      step  <= step_d;
      out_0 <= dec_d ^ POL_MASK;
    end
  end

endmodule

// File: tb/tb_decoder_n_scan.sv
// tb_decoder_n_scan
// Drives three decoder_n_scan instances (different DIV_CNT / polarity) from
// shared inputs. The driver predicts each cycle's outputs with a timing model
// (scan steps fall every DIV_CNT edges after entering scan) and queues them;
// the monitor pops one expectation after every rising edge and compares.
module tb_decoder_n_scan;

  localparam int NDUT = 3;

  typedef struct packed {
    logic [NDUT-1:0][7:0] out_0;
    logic [NDUT-1:0][2:0] idx;
    logic [NDUT-1:0]      step;
  } exp_t;

  logic       sys_clk = 1'b0;
  logic       sys_rst;
  logic       en;
  logic       mode;
  logic [2:0] sel;
  logic       sel_vld;

  logic [7:0] out_w  [NDUT];
  logic [2:0] idx_w  [NDUT];
  logic       step_w [NDUT];

  int div_cfg [NDUT] = '{4, 3, 1};
  bit al_cfg  [NDUT] = '{1'b0, 1'b1, 1'b0};

  int  m_idx   [NDUT];
  bit  m_active[NDUT];
  bit  m_scan  [NDUT];
  int  m_entry [NDUT];
  bit  m_step  [NDUT];
  int  edge_no;

  exp_t exp_q[$];
  int   total;
  int   bad;
  int   cyc;

  always #5 sys_clk = ~sys_clk;

  decoder_n_scan #(.SEL_W(3), .DIV_CNT(4), .ACTIVE_LOW(1'b0)) dut_a (
    .sys_clk (sys_clk), .sys_rst (sys_rst), .en (en), .mode (mode),
    .sel (sel), .sel_vld (sel_vld),
    .out_0 (out_w[0]), .idx (idx_w[0]), .step (step_w[0])
  );

  decoder_n_scan #(.SEL_W(3), .DIV_CNT(3), .ACTIVE_LOW(1'b1)) dut_b (
    .sys_clk (sys_clk), .sys_rst (sys_rst), .en (en), .mode (mode),
    .sel (sel), .sel_vld (sel_vld),
    .out_0 (out_w[1]), .idx (idx_w[1]), .step (step_w[1])
  );

  decoder_n_scan #(.SEL_W(3), .DIV_CNT(1), .ACTIVE_LOW(1'b0)) dut_c (
    .sys_clk (sys_clk), .sys_rst (sys_rst), .en (en), .mode (mode),
    .sel (sel), .sel_vld (sel_vld),
    .out_0 (out_w[2]), .idx (idx_w[2]), .step (step_w[2])
  );

  // Drive one cycle of inputs, predict the result of the coming edge for
  // every instance, queue it, then wait for the next falling edge
  task automatic applyStimulus(input logic r, input logic e, input logic m,
                               input logic v, input logic [2:0] s);
    exp_t       x;
    logic [7:0] pattern;
    sys_rst = r;
    en      = e;
    mode    = m;
    sel_vld = v;
    sel     = s;
    edge_no++;
    for (int k = 0; k < NDUT; k++) begin
      m_step[k] = 1'b0;
      if (r) begin
        m_idx[k]    = 0;
        m_active[k] = 1'b0;
        m_scan[k]   = 1'b0;
      end else if (!e) begin
        m_active[k] = 1'b0;
        m_scan[k]   = 1'b0;
      end else if (!m) begin
        if (v) m_idx[k] = int'(s);
        m_active[k] = 1'b1;
        m_scan[k]   = 1'b0;
      end else begin
        m_active[k] = 1'b1;
        if (!m_scan[k]) begin
          m_scan[k]  = 1'b1;
          m_entry[k] = edge_no;
        end else if ((edge_no - m_entry[k]) % div_cfg[k] == 0) begin
          m_step[k] = 1'b1;
          m_idx[k]  = (m_idx[k] + 1) % 8;
        end
      end
      pattern = m_active[k] ? (8'd1 << m_idx[k]) : 8'd0;
      if (al_cfg[k]) pattern = ~pattern;
      x.out_0[k] = pattern;
      x.idx[k]   = 3'(m_idx[k]);
      x.step[k]  = m_step[k];
    end
    exp_q.push_back(x);
    @(negedge sys_clk);
  endtask

  task automatic checkOutput(input string name, input int k,
                             input logic [7:0] got, input logic [7:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("[TB] FAIL %s dut=%0d cyc=%0d got=%h want=%h", name, k, cyc, got, want);
    end
  endtask

  // Monitor: every rising edge the DUTs present new outputs
  initial begin
    exp_t x;
    cyc = 0;
    forever begin
      @(posedge sys_clk);
      #1;
      cyc++;
      if (exp_q.size() != 0) begin
        x = exp_q.pop_front();
        for (int k = 0; k < NDUT; k++) begin
          checkOutput("out_0", k, out_w[k], x.out_0[k]);
          checkOutput("idx", k, {5'd0, idx_w[k]}, {5'd0, x.idx[k]});
          checkOutput("step", k, {7'd0, step_w[k]}, {7'd0, x.step[k]});
        end
      end
    end
  end

  initial begin
    logic cur_mode;
    logic cur_en;
    int   wait_cycles;
    total   = 0;
    bad     = 0;
    edge_no = 0;
    for (int k = 0; k < NDUT; k++) begin
      m_idx[k] = 0; m_active[k] = 0; m_scan[k] = 0; m_entry[k] = 0; m_step[k] = 0;
    end

    $display("[TB] reset");
    applyStimulus(1, 0, 0, 0, 3'd0);
    applyStimulus(1, 0, 0, 0, 3'd0);
    applyStimulus(0, 0, 0, 0, 3'd0);

    $display("[TB] direct load");
    applyStimulus(0, 1, 0, 1, 3'd5);
    applyStimulus(0, 1, 0, 0, 3'd1);
    applyStimulus(0, 1, 0, 0, 3'd7);

    $display("[TB] scan with wrap from idx 6");
    applyStimulus(0, 1, 0, 1, 3'd6);
    for (int i = 0; i < 13; i++) applyStimulus(0, 1, 1, 1, 3'(i));

    $display("[TB] polarity and enable");
    applyStimulus(0, 1, 0, 1, 3'd2);
    applyStimulus(0, 1, 0, 0, 3'd0);
    applyStimulus(0, 0, 0, 1, 3'd4);
    applyStimulus(0, 0, 0, 0, 3'd4);

    $display("[TB] scan to direct with simultaneous load");
    for (int i = 0; i < 6; i++) applyStimulus(0, 1, 1, 0, 3'd0);
    applyStimulus(0, 1, 0, 1, 3'd3);
    for (int i = 0; i < 6; i++) applyStimulus(0, 1, 0, 0, 3'd0);

    $display("[TB] reset mid-scan");
    for (int i = 0; i < 5; i++) applyStimulus(0, 1, 1, 0, 3'd0);
    applyStimulus(1, 1, 1, 0, 3'd0);
    for (int i = 0; i < 10; i++) applyStimulus(0, 1, 1, 0, 3'd0);

    $display("[TB] randomized traffic");
    cur_mode = 1'b0;
    cur_en   = 1'b1;
    for (int i = 0; i < 500; i++) begin
      if ($urandom_range(0, 7) == 0) cur_mode = ~cur_mode;
      if ($urandom_range(0, 11) == 0) cur_en = ~cur_en;
      applyStimulus(($urandom_range(0, 59) == 0) ? 1'b1 : 1'b0, cur_en, cur_mode,
                    ($urandom_range(0, 3) == 0) ? 1'b1 : 1'b0,
                    3'($urandom_range(0, 7)));
    end

    wait_cycles = 0;
    while (exp_q.size() != 0 && wait_cycles < 10) begin
      @(negedge sys_clk);
      wait_cycles++;
    end
    if (exp_q.size() != 0) begin
      total++;
      bad++;
      $display("[TB] FAIL drain got=%0d want=0", exp_q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
